// File: rtl/iter_muldiv_calc_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iter_muldiv_calc_if : operand load / control / result bundle     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface iter_muldiv_calc_if #(
   parameter int W = 32
);
   localparam int LANES = W / 8;
   localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int SW    = ((2 * W / 16) > 1) ? $clog2(2 * W / 16) : 1;

   logic            load_en;
   logic            load_x;
   logic [LW-1:0]   load_lane;
   logic [7:0]      in_data;
   logic            start;
   logic            op_mul;
   logic            is_signed;
   logic            busy;
   logic            done;
   logic            div_zero;
   logic [2*W-1:0]  result;
   logic [SW-1:0]   disp_sel;
   logic [15:0]     disp_data;

   modport master (
      output load_en, load_x, load_lane, in_data, start, op_mul, is_signed, disp_sel,
      input  busy, done, div_zero, result, disp_data
   );

   modport slave (
      input  load_en, load_x, load_lane, in_data, start, op_mul, is_signed, disp_sel,
      output busy, done, div_zero, result, disp_data
   );
endinterface
`default_nettype wire

// File: rtl/iter_muldiv_calc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iter_muldiv_calc : one-bit-per-cycle shift-add mul / restoring   |
// | div core. Optional macro MULDIV_SIGNED_EN adds two's complement. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module iter_muldiv_calc #(
   parameter int W = 32
) (
   input  logic               clk,
   input  logic               clear,
   iter_muldiv_calc_if.slave  bus
);
   localparam int LANES = W / 8;
   localparam int NWIN  = 2 * W / 16;
   localparam int CW    = $clog2(W + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]     state_q, state_d;
   logic [W-1:0]   x_q, x_d, y_q, y_d;
   logic [2*W-1:0] acc_q, acc_d;
   logic [W-1:0]   opnd_q, opnd_d;
   logic           op_mul_q, op_mul_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*W-1:0] result_q, result_d;
   logic           done_q, done_d;
   logic           div_zero_q, div_zero_d;

   logic           busy;
   logic           last;
   logic           take_start;
   logic [W-1:0]   mag_x, mag_y;
   logic [2*W-1:0] step, fin;
   logic [W:0]     mul_sum, div_r, div_rs;
   logic           div_ge;

   assign last       = (cnt_q == CW'(1));
   assign take_start = (state_q == S_IDLE) && bus.start;

   // acc holds {high product, remaining multiplier} for mul and
   // {partial remainder, dividend/quotient} for div.
   always_comb begin
      mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_r   = {acc_q[2*W-1:W], acc_q[W-1]};
      div_ge  = (div_r >= {1'b0, opnd_q});
      div_rs  = div_ge ? (div_r - {1'b0, opnd_q}) : div_r;
      step    = op_mul_q ? {mul_sum, acc_q[W-1:1]}
                         : {div_rs[W-1:0], acc_q[W-2:0], div_ge};
   end

`ifdef MULDIV_SIGNED_EN
   logic neg_a_q, neg_a_d, neg_b_q, neg_b_d;
   logic sx, sy;

   // neg_a: product / quotient sign, neg_b: remainder sign (dividend's).
   always_comb begin
      sx      = bus.is_signed & x_q[W-1];
      sy      = bus.is_signed & y_q[W-1];
      mag_x   = sx ? -x_q : x_q;
      mag_y   = sy ? -y_q : y_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      if (take_start) begin
         neg_a_d = bus.op_mul ? (sx ^ sy) : ((sx ^ sy) & (y_q != '0));
         neg_b_d = bus.op_mul ? 1'b0 : sx;
      end
      if (op_mul_q) begin
         fin = neg_a_q ? -step : step;
      end else begin
         fin = {(neg_b_q ? -step[2*W-1:W] : step[2*W-1:W]),
                (neg_a_q ? -step[W-1:0]   : step[W-1:0])};
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
      end else begin
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
      end
   end
`else
   logic unused_is_signed;
   assign unused_is_signed = bus.is_signed;

   always_comb begin
      mag_x = x_q;
      mag_y = y_q;
      fin   = step;
   end
`endif

   // State register
   always_ff @(posedge clk) begin
      if (clear) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN:   if (last)      state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == S_RUN);
   end

   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      op_mul_d   = op_mul_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;

      if (bus.load_en && (int'(bus.load_lane) < LANES)) begin
         if (bus.load_x) x_d[{bus.load_lane, 3'b000} +: 8] = bus.in_data;
         else            y_d[{bus.load_lane, 3'b000} +: 8] = bus.in_data;
      end

      if (take_start) begin
         op_mul_d   = bus.op_mul;
         opnd_d     = bus.op_mul ? mag_x : mag_y;
         acc_d      = {{W{1'b0}}, (bus.op_mul ? mag_y : mag_x)};
         cnt_d      = CW'(W);
         div_zero_d = 1'b0;
      end else if (state_q == S_RUN) begin
         acc_d = step;
         cnt_d = cnt_q - CW'(1);
         if (last) begin
            result_d   = fin;
            done_d     = 1'b1;
            div_zero_d = !op_mul_q && (opnd_q == '0);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         x_q        <= '0;
         y_q        <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         op_mul_q   <= 1'b0;
         cnt_q      <= '0;
         result_q   <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         x_q        <= x_d;
         y_q        <= y_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         op_mul_q   <= op_mul_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   always_comb begin
      bus.disp_data = 16'h0000;
      if (int'(bus.disp_sel) < NWIN) bus.disp_data = result_q[{bus.disp_sel, 4'b0000} +: 16];
   end

   assign bus.busy     = busy;
   assign bus.done     = done_q;
   assign bus.div_zero = div_zero_q;
   assign bus.result   = result_q;
endmodule
`default_nettype wire

// File: tb/tb_iter_muldiv_calc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_iter_muldiv_calc : directed + random bench with arithmetic    |
// | reference model. Rev 1.0                                         |
// +------------------------------------------------------------------+
module tb_iter_muldiv_calc;
   localparam int W = 32;

   logic clk;
   logic clear;
   int   n_tests = 0;
   int   n_fail  = 0;

   iter_muldiv_calc_if #(.W(W)) bus ();

   iter_muldiv_calc #(.W(W)) dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Expected result straight from integer arithmetic.
   function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic mul, input logic sgn);
      logic        eff;
      logic signed [63:0] sx, sy, t, q, r;
`ifdef MULDIV_SIGNED_EN
      eff = sgn;
`else
      eff = sgn & 1'b0;
`endif
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      if (mul) begin
         if (eff) begin
            t = sx * sy;
            return t;
         end
         return {32'b0, x} * {32'b0, y};
      end
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (eff) begin
         q = sx / sy;
         r = sx % sy;
         return {r[31:0], q[31:0]};
      end
      return {x % y, x / y};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic is_x, input logic [31:0] v);
      for (int k = 0; k < 4; k++) begin
         bus.load_en   = 1'b1;
         bus.load_x    = is_x;
         bus.load_lane = 2'(k);
         bus.in_data   = v[8*k +: 8];
         tick();
      end
      bus.load_en = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!bus.done && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic mul, input logic sgn);
      int lat;
      load_word(1'b1, x);
      load_word(1'b0, y);
      bus.op_mul    = mul;
      bus.is_signed = sgn;
      bus.start     = 1'b1;
      tick();
      bus.start = 1'b0;
      check({tag, " busy@start"}, {63'b0, bus.busy}, 64'd1);
      check({tag, " dz@start"}, {63'b0, bus.div_zero}, 64'd0);
      wait_done(lat);
      check({tag, " latency"}, 64'(lat), 64'(W));
      check({tag, " busy@done"}, {63'b0, bus.busy}, 64'd0);
      check({tag, " result"}, bus.result, model(x, y, mul, sgn));
      check({tag, " div_zero"}, {63'b0, bus.div_zero}, {63'b0, (!mul && y == 32'd0)});
      tick();
      check({tag, " done pulse"}, {63'b0, bus.done}, 64'd0);
   endtask

   initial begin
      int lat;
      int pulses;
      logic [31:0] rx, ry;
      logic        rm, rs;

      clear         = 1'b1;
      bus.load_en   = 1'b0;
      bus.load_x    = 1'b0;
      bus.load_lane = '0;
      bus.in_data   = '0;
      bus.start     = 1'b0;
      bus.op_mul    = 1'b0;
      bus.is_signed = 1'b0;
      bus.disp_sel  = '0;
      tick();
      tick();
      clear = 1'b0;
      check("rst result", bus.result, 64'd0);
      check("rst busy", {63'b0, bus.busy}, 64'd0);
      check("rst done", {63'b0, bus.done}, 64'd0);
      check("rst div_zero", {63'b0, bus.div_zero}, 64'd0);
      check("rst disp", {48'b0, bus.disp_data}, 64'd0);

      run_op("mul max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      check("mul max const", bus.result, 64'hFFFF_FFFE_0000_0001);
      run_op("div 100/7", 32'd100, 32'd7, 1'b0, 1'b0);
      check("div 100/7 const", bus.result, {32'd2, 32'd14});
      run_op("div by 0", 32'd5, 32'd0, 1'b0, 1'b0);
      check("div0 const", bus.result, {32'd5, 32'hFFFF_FFFF});
      run_op("mul after div0", 32'd9, 32'd11, 1'b1, 1'b0);

      // Byte-lane load and display windows
      run_op("lanes", 32'h1234_5678, 32'd1, 1'b1, 1'b0);
      for (int s = 0; s < 4; s++) begin
         logic [63:0] r;
         r = 64'h0000_0000_1234_5678;
         bus.disp_sel = 2'(s);
         #1;
         check("disp window", {48'b0, bus.disp_data}, {48'b0, r[16*s +: 16]});
      end
      bus.disp_sel = '0;

      // start + load on the same edge uses pre-load operands
      load_word(1'b1, 32'd10);
      load_word(1'b0, 32'd3);
      bus.op_mul    = 1'b1;
      bus.is_signed = 1'b0;
      bus.start     = 1'b1;
      bus.load_en   = 1'b1;
      bus.load_x    = 1'b1;
      bus.load_lane = 2'd0;
      bus.in_data   = 8'hFF;
      tick();
      bus.start   = 1'b0;
      bus.load_en = 1'b0;
      wait_done(lat);
      check("start+load result", bus.result, 64'd30);

      // start coinciding with done is ignored
      tick();
      load_word(1'b1, 32'd6);
      load_word(1'b0, 32'd7);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int c = 1; c < W; c++) tick();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("done edge start done", {63'b0, bus.done}, 64'd1);
      check("done edge start result", bus.result, 64'd42);
      tick();
      check("done edge start ignored", {63'b0, bus.busy}, 64'd0);

      // Abort via clear mid-operation, with an ignored start while running
      load_word(1'b1, 32'd3);
      load_word(1'b0, 32'd4);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 10; c++) begin
         bus.start = (c == 5);
         clear     = (c == 10);
         tick();
         if (bus.done) pulses++;
      end
      bus.start = 1'b0;
      clear     = 1'b0;
      check("abort busy", {63'b0, bus.busy}, 64'd0);
      check("abort result", bus.result, 64'd0);
      for (int c = 0; c < 40; c++) begin
         tick();
         if (bus.done) pulses++;
      end
      check("abort no done", 64'(pulses), 64'd0);
      run_op("after abort", 32'd3, 32'd4, 1'b1, 1'b0);

      // Signed directed cases (model is unsigned when the macro is off)
      run_op("s div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
`ifdef MULDIV_SIGNED_EN
      check("s div const", bus.result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
      check("u div const", bus.result, {32'd1, 32'h7FFF_FFFC});
`endif
      run_op("s mul -3*5", 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
      run_op("s div -9/0", 32'hFFFF_FFF7, 32'd0, 1'b0, 1'b1);

      for (int i = 0; i < 24; i++) begin
         rx = $urandom;
         ry = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 2) == 0) ry = ry & 32'h0000_00FF;
         rm = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         run_op("rand", rx, ry, rm, rs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
